// File: rtl/dmem_responder.sv
// Data-memory responder for the hart dmem port: word-organised, byte-masked RAM
// with a fixed, handshaked request-to-response latency.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_busy,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD    = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
  localparam logic [29:0]   DEPTH_LIMIT = 30'(DEPTH_WORDS);

  if (LATENCY < 1) begin : g_latency_check
    $error("dmem_responder: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            accept;

  logic [AW-1:0]   lat_idx_reg;
  logic [3:0]      lat_mask_reg;
  logic [31:0]     lat_wdata_reg;
  logic            lat_write_reg;
  logic            lat_err_reg;
  logic            err_resp_reg;

  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic            from_wait;
  logic            commit;
  logic [AW-1:0]   c_idx;
  logic [3:0]      c_mask;
  logic [31:0]     c_wdata;
  logic            c_write;
  logic            c_err;
  logic            c_read_ok;
  logic            mem_we;

  // Out-of-range upper address bits fault rather than alias onto the array.
  assign req_err = (i_dmem_addr[1:0] != 2'b00)
                 || (i_dmem_addr[31:2] >= DEPTH_LIMIT)
                 || (i_dmem_mask == 4'b0000)
                 || (i_dmem_ren && i_dmem_wen);
  assign req_idx = i_dmem_addr[AW+1:2];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, RESP: begin
        accept = i_dmem_ren | i_dmem_wen;
        if (accept) begin
          state_next = (LATENCY == 1) ? RESP : WAIT;
          cnt_next   = CNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_dmem_busy  = (state_reg == WAIT);
    o_dmem_valid = (state_reg == RESP);
    o_dmem_err   = (state_reg == RESP) && err_resp_reg;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lat_idx_reg   <= req_idx;
      lat_mask_reg  <= i_dmem_mask;
      lat_wdata_reg <= i_dmem_wdata;
      lat_write_reg <= i_dmem_wen;
      lat_err_reg   <= req_err;
    end
  end

  // The commit happens on the edge entering RESP; with LATENCY=1 that is the
  // accept edge itself, so the request is taken straight from the inputs.
  assign from_wait = (state_reg == WAIT);
  assign commit    = (state_next == RESP) && i_rst_n;
  assign c_idx     = from_wait ? lat_idx_reg   : req_idx;
  assign c_mask    = from_wait ? lat_mask_reg  : i_dmem_mask;
  assign c_wdata   = from_wait ? lat_wdata_reg : i_dmem_wdata;
  assign c_write   = from_wait ? lat_write_reg : i_dmem_wen;
  assign c_err     = from_wait ? lat_err_reg   : req_err;
  assign c_read_ok = !c_write && !c_err;
  assign mem_we    = commit && c_write && !c_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    err_resp_reg <= 1'b0;
    else if (commit) err_resp_reg <= c_err;
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_lane_reg;

    always_ff @(posedge i_clk) begin
      if (mem_we && c_mask[gi]) mem[c_idx] <= c_wdata[8*gi +: 8];
    end

    // Unmasked lanes and faulted requests read back as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    rd_lane_reg <= 8'h00;
      else if (commit) rd_lane_reg <= (c_read_ok && c_mask[gi]) ? mem[c_idx] : 8'h00;
    end

    assign o_dmem_rdata[8*gi +: 8] = rd_lane_reg;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 1, 2 and 3
// driven by directed requests; a negedge monitor checks every response.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  mask  [3];
  logic [31:0] rdata [3];
  logic [2:0]  ren, wen, busy, valid, err;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(gi + 1)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[gi]),
      .i_dmem_addr (addr[gi]),
      .i_dmem_ren  (ren[gi]),
      .i_dmem_wen  (wen[gi]),
      .i_dmem_wdata(wdata[gi]),
      .i_dmem_mask (mask[gi]),
      .o_dmem_busy (busy[gi]),
      .o_dmem_valid(valid[gi]),
      .o_dmem_rdata(rdata[gi]),
      .o_dmem_err  (err[gi])
    );
  end

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request for one cycle; instance k has LATENCY k+1.
  task automatic issue(input int k, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [3:0] m, input bit expect_resp,
                       input logic [31:0] erd, input logic eerr, input bit chk_rd);
    addr[k]  = a;
    ren[k]   = r;
    wen[k]   = w;
    wdata[k] = d;
    mask[k]  = m;
    if (expect_resp)
      sb.push_back('{inst: k, cyc: cyc + k + 1, rdata: erd, err: eerr, chk_rdata: chk_rd});
    @(posedge clk);
    #1;
    ren[k] = 1'b0;
    wen[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid[k] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: inst %0d cycle %0d got valid=1, expected 0", k, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("resp_inst", 32'(k), 32'(mon_e.inst));
          check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("resp_err", 32'(err[k]), 32'(mon_e.err));
          if (mon_e.chk_rdata) check("resp_rdata", rdata[k], mon_e.rdata);
          check("busy_in_resp", 32'(busy[k]), 32'd0);
          $display("resp inst=%0d lat=%0d cyc=%0d err=%0b rdata=%08h", k, k + 1, cyc, err[k], rdata[k]);
        end
      end else begin
        check("err_without_valid", 32'(err[k]), 32'd0);
      end
    end
    check("lat1_never_busy", 32'(busy[0]), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 3'b111;
    ren   = '0;
    wen   = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k]  = '0;
      wdata[k] = '0;
      mask[k]  = '0;
    end
    #1 rst_n = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_valid", 32'(valid[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_rdata", rdata[k], 32'd0);
    end
    rst_n = 3'b111;
    @(posedge clk);
    #1;

    // LATENCY=2: full write, busy in C+1, readback
    issue(1, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
    check("lat2_busy_c1", 32'(busy[1]), 32'd1);
    drain();
    issue(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    drain();

    // Byte write into lane 2, then full and half-word reads
    issue(1, 32'h10, 1'b0, 1'b1, 32'h00AA0000, 4'b0100, 1'b1, 32'h0, 1'b0, 1'b0);
    drain();
    issue(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hDEAABEEF, 1'b0, 1'b1);
    drain();
    issue(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1100, 1'b1, 32'hDEAA0000, 1'b0, 1'b1);
    drain();

    // Error cases; word 0 guards against the out-of-range address aliasing
    issue(1, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
    drain();
    issue(1, 32'h13, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0, 1'b1, 1'b1);
    drain();
    issue(1, 32'h1000, 1'b0, 1'b1, 32'h55555555, 4'b1111, 1'b1, 32'h0, 1'b1, 1'b1);
    drain();
    issue(1, 32'h10, 1'b0, 1'b1, 32'h22222222, 4'b0000, 1'b1, 32'h0, 1'b1, 1'b1);
    drain();
    issue(1, 32'h10, 1'b1, 1'b1, 32'h11111111, 4'b1111, 1'b1, 32'h0, 1'b1, 1'b1);
    drain();
    issue(1, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hDEAABEEF, 1'b0, 1'b1);
    drain();
    issue(1, 32'h0, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // LATENCY=1: write then read back-to-back
    issue(0, 32'h20, 1'b0, 1'b1, 32'h12345678, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(0, 32'h20, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'h12345678, 1'b0, 1'b1);
    drain();

    // LATENCY=3: requests while busy are ignored
    issue(2, 32'h30, 1'b0, 1'b1, 32'hA5A5A5A5, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
    check("lat3_busy_c1", 32'(busy[2]), 32'd1);
    issue(2, 32'h30, 1'b0, 1'b1, 32'h0BADF00D, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0);
    check("lat3_busy_c2", 32'(busy[2]), 32'd1);
    issue(2, 32'h30, 1'b0, 1'b1, 32'h0BADF00D, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0);
    drain();
    issue(2, 32'h30, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain();

    // Reset while a write is in flight: dropped, no pulse, memory intact
    issue(2, 32'h30, 1'b0, 1'b1, 32'h77777777, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_busy_before", 32'(busy[2]), 32'd1);
    #2 rst_n[2] = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy[2]), 32'd0);
    check("rst_async_valid", 32'(valid[2]), 32'd0);
    check("rst_async_err", 32'(err[2]), 32'd0);
    check("rst_async_rdata", rdata[2], 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n[2] = 1'b1;
    @(posedge clk);
    #1;
    issue(2, 32'h30, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain();

    // Idle: no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        check("idle_busy", 32'(busy[k]), 32'd0);
        check("idle_valid", 32'(valid[k]), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
